// File: rtl/router_fsm_if.sv
// Control bundle between the router source side, the FSM, the FIFO status and the register stage.
// The slave modport is the FSM's view; master is the view of whatever surrounds it.
interface router_fsm_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;

    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );

    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-flow controller for the 1x3 router: decodes header address, sequences header/payload/parity loads.
// Latency: Moore outputs decoded from the state register, valid the cycle after each transition edge.
// Backpressure: fifo_full parks the FSM in FIFO_FULL_STATE with busy high; soft_reset of the active port aborts to DA.
module router_fsm #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    router_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              addr_ok;

    assign addr_ok = int'(bus.data_in) < NUM_PORTS;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && addr_ok) begin
                    addr_d  = bus.data_in;
                    state_d = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                // A full FIFO must stall even if the parity byte is arriving this cycle.
                if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_d = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
                else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (bus.fifo_empty[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // Timeout from the active port abandons the packet; idle DA is unaffected.
        if (state_q != DECODE_ADDRESS && bus.soft_reset[addr_q]) begin
            state_d = DECODE_ADDRESS;
        end
    end

    assign bus.detect_add    = (state_q == DECODE_ADDRESS);
    assign bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign bus.ld_state      = (state_q == LOAD_DATA);
    assign bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    assign bus.full_state    = (state_q == FIFO_FULL_STATE);
    assign bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                               (state_q == LOAD_PARITY);
    assign bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each scenario task drives vectors and compares the output
// strobes {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy} against hand-derived values.
module tb_router_fsm;

    logic clock;
    logic resetn;
    int   n_checks;
    int   n_fail;

    router_fsm_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();

    router_fsm #(.NUM_PORTS(3), .ADDR_W(2)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] outs;
    assign outs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                   bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0010;
    localparam logic [7:0] O_LAF = 8'b0001_0011;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0011;
    localparam logic [7:0] O_CPE = 8'b0000_0101;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'b00;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = 3'b111;
        bus.soft_reset    = 3'b000;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
    endtask

    // From DA, walk through LFD into LD for the given port (no comparisons).
    task automatic goto_ld(input logic [1:0] port);
        bus.fifo_empty = 3'b111;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = port;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'b01;
        bus.fifo_full  = 1'b1;
        bus.fifo_empty = 3'b000;
        bus.soft_reset = 3'b111;
        bus.parity_done = 1'b1;
        bus.low_pkt_valid = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL reset_outs: got %b want %b", outs, O_DA);
        end
        n_checks++;
        if (dut.addr_q !== 2'b00) begin
            n_fail++; $display("FAIL reset_addr: got %b want 00", dut.addr_q);
        end
        idle_inputs();
        resetn = 1'b1;
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL reset_idle: got %b want %b", outs, O_DA);
        end
    endtask

    task automatic test_basic_packet();
        logic [7:0] exp [5];
        exp = '{O_LFD, O_LD, O_LP, O_CPE, O_DA};
        bus.fifo_empty = 3'b111;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 1) bus.pkt_valid = 1'b0;
            n_checks++;
            if (outs !== exp[i]) begin
                n_fail++; $display("FAIL basic_step%0d: got %b want %b", i, outs, exp[i]);
            end
        end
        n_checks++;
        if (dut.addr_q !== 2'b01) begin
            n_fail++; $display("FAIL basic_addr: got %b want 01", dut.addr_q);
        end
    endtask

    task automatic test_wait_empty();
        bus.fifo_empty = 3'b011;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'b10;
        tick();
        n_checks++;
        if (outs !== O_WTE) begin
            n_fail++; $display("FAIL wte_enter: got %b want %b", outs, O_WTE);
        end
        // Emptiness of other ports must not release the wait.
        bus.data_in    = 2'b00;
        tick();
        n_checks++;
        if (outs !== O_WTE) begin
            n_fail++; $display("FAIL wte_hold: got %b want %b", outs, O_WTE);
        end
        bus.fifo_empty = 3'b111;
        tick();
        n_checks++;
        if (outs !== O_LFD) begin
            n_fail++; $display("FAIL wte_release: got %b want %b", outs, O_LFD);
        end
        tick();
        bus.pkt_valid = 1'b0;
        tick();
        tick();
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL wte_done: got %b want %b", outs, O_DA);
        end
    endtask

    task automatic test_fifo_full();
        goto_ld(2'b00);
        bus.fifo_full = 1'b1;
        tick();
        n_checks++;
        if (outs !== O_FFS) begin
            n_fail++; $display("FAIL full_enter: got %b want %b", outs, O_FFS);
        end
        tick();
        n_checks++;
        if (outs !== O_FFS) begin
            n_fail++; $display("FAIL full_hold: got %b want %b", outs, O_FFS);
        end
        bus.fifo_full = 1'b0;
        tick();
        n_checks++;
        if (outs !== O_LAF) begin
            n_fail++; $display("FAIL full_laf: got %b want %b", outs, O_LAF);
        end
        bus.low_pkt_valid = 1'b1;
        tick();
        n_checks++;
        if (outs !== O_LP) begin
            n_fail++; $display("FAIL laf_to_lp: got %b want %b", outs, O_LP);
        end
        // CPE sees fifo_full and must go back to the full state.
        bus.low_pkt_valid = 1'b0;
        tick();
        bus.fifo_full = 1'b1;
        tick();
        n_checks++;
        if (outs !== O_FFS) begin
            n_fail++; $display("FAIL cpe_to_ffs: got %b want %b", outs, O_FFS);
        end
        bus.fifo_full   = 1'b0;
        bus.parity_done = 1'b1;
        tick();
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL laf_parity_done: got %b want %b", outs, O_DA);
        end
        bus.parity_done = 1'b0;
        // LAF with neither flag returns to LD.
        goto_ld(2'b00);
        bus.fifo_full = 1'b1;
        tick();
        bus.fifo_full = 1'b0;
        tick();
        tick();
        n_checks++;
        if (outs !== O_LD) begin
            n_fail++; $display("FAIL laf_to_ld: got %b want %b", outs, O_LD);
        end
        // fifo_full wins over pkt_valid falling in LD.
        bus.fifo_full = 1'b1;
        bus.pkt_valid = 1'b0;
        tick();
        n_checks++;
        if (outs !== O_FFS) begin
            n_fail++; $display("FAIL ld_full_priority: got %b want %b", outs, O_FFS);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        idle_inputs();
    endtask

    task automatic test_invalid_addr();
        bus.fifo_empty = 3'b111;
        bus.pkt_valid  = 1'b1;
        bus.data_in    = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (outs !== O_DA) begin
                n_fail++; $display("FAIL bad_addr_cyc%0d: got %b want %b", i, outs, O_DA);
            end
        end
        n_checks++;
        if (dut.addr_q !== 2'b00) begin
            n_fail++; $display("FAIL bad_addr_held: got %b want 00", dut.addr_q);
        end
        bus.pkt_valid = 1'b0;
    endtask

    task automatic test_soft_reset();
        goto_ld(2'b00);
        bus.soft_reset = 3'b010;
        tick();
        n_checks++;
        if (outs !== O_LD) begin
            n_fail++; $display("FAIL srst_other_port: got %b want %b", outs, O_LD);
        end
        bus.soft_reset = 3'b001;
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL srst_own_port: got %b want %b", outs, O_DA);
        end
        // Soft reset in DA does not block a new header.
        bus.data_in = 2'b00;
        tick();
        n_checks++;
        if (outs !== O_LFD) begin
            n_fail++; $display("FAIL srst_in_da: got %b want %b", outs, O_LFD);
        end
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL srst_lfd: got %b want %b", outs, O_DA);
        end
        bus.soft_reset = 3'b000;
        bus.pkt_valid  = 1'b0;
    endtask

    task automatic test_reset_in_full();
        goto_ld(2'b10);
        bus.fifo_full = 1'b1;
        tick();
        n_checks++;
        if (outs !== O_FFS) begin
            n_fail++; $display("FAIL rst_setup_ffs: got %b want %b", outs, O_FFS);
        end
        resetn = 1'b0;
        tick();
        n_checks++;
        if (outs !== O_DA) begin
            n_fail++; $display("FAIL rst_from_ffs: got %b want %b", outs, O_DA);
        end
        n_checks++;
        if (dut.addr_q !== 2'b00) begin
            n_fail++; $display("FAIL rst_addr_clear: got %b want 00", dut.addr_q);
        end
        resetn = 1'b1;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        resetn = 1'b0;
        #1;
        test_reset();
        test_basic_packet();
        test_wait_empty();
        test_fifo_full();
        test_invalid_addr();
        test_soft_reset();
        test_reset_in_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
